psum_reduce_ctrl: RTL

PSUM_REDUCE_CTRL -- requirements
Module: psum_reduce_ctrl

---
 rtl/psum_reduce_ctrl_if.sv | 27 ++
 rtl/psum_reduce_ctrl.sv | 166 ++++++++++++++++
 2 files changed

// File: rtl/psum_reduce_ctrl_if.sv
// Partial-sum reduction controller bundle: job control,
// partial-sum input handshake, result output handshake.
interface psum_reduce_ctrl_if #(
    parameter int IN_W  = 19,
    parameter int OUT_W = 21
);
    logic                    start;
    logic                    busy;
    logic                    in_valid;
    logic                    in_ready;
    logic signed [IN_W-1:0]  in_data;
    logic                    out_valid;
    logic                    out_ready;
    logic signed [OUT_W-1:0] out_data;
    logic                    out_sat;
    logic                    add_en;

    modport master (
        output start, in_valid, in_data, out_ready,
        input  busy, in_ready, out_valid, out_data, out_sat, add_en
    );

    modport slave (
        input  start, in_valid, in_data, out_ready,
        output busy, in_ready, out_valid, out_data, out_sat, add_en
    );
endinterface

// File: rtl/psum_reduce_ctrl.sv
// Reduces N_TERMS signed partial sums two at a time through one 3-input adder.
// Define PSUM_SATURATE_EN to clamp the result instead of wrapping it.
module psum_reduce_ctrl #(
    parameter int N_TERMS = 9,
    parameter int IN_W    = 19,
    parameter int OUT_W   = 21,
    parameter int ACC_W   = 28
) (
    input  logic                clk,
    input  logic                rst,
    psum_reduce_ctrl_if.slave   bus
);

    localparam logic [7:0] NT = 8'(N_TERMS);

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        ADD,
        DONE
    } state_t;

    state_t state, state_nxt;

    logic [7:0]              cnt;
    logic                    a_full;
    logic signed [IN_W-1:0]  slot_a;
    logic signed [IN_W-1:0]  slot_b;
    logic signed [ACC_W-1:0] acc;
    logic signed [ACC_W-1:0] ext_a;
    logic signed [ACC_W-1:0] ext_b;

    logic busy;
    logic in_ready;
    logic out_valid;
    logic add_en;
    logic take;
    logic last;

    logic signed [OUT_W-1:0] out_q;
    logic                    sat_q;

    assign take  = in_ready & bus.in_valid;
    assign last  = ((cnt + 8'd1) == NT);
    assign ext_a = {{(ACC_W-IN_W){slot_a[IN_W-1]}}, slot_a};
    assign ext_b = {{(ACC_W-IN_W){slot_b[IN_W-1]}}, slot_b};

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // Next state and strobes; a lone final term goes to the adder with B zero.
    always_comb begin
        state_nxt = state;
        busy      = 1'b0;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        add_en    = 1'b0;
        unique case (state)
            IDLE: begin
                if (bus.start) state_nxt = LOAD;
            end
            LOAD: begin
                busy     = 1'b1;
                in_ready = 1'b1;
                if (take && (a_full || last)) state_nxt = ADD;
            end
            ADD: begin
                busy      = 1'b1;
                add_en    = 1'b1;
                state_nxt = (cnt == NT) ? DONE : LOAD;
            end
            DONE: begin
                busy      = 1'b1;
                out_valid = 1'b1;
                if (bus.out_ready) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Pair buffer, term count and accumulator.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt    <= '0;
            a_full <= 1'b0;
            slot_a <= '0;
            slot_b <= '0;
            acc    <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (bus.start) begin
                        cnt    <= '0;
                        a_full <= 1'b0;
                        slot_a <= '0;
                        slot_b <= '0;
                        acc    <= '0;
                    end
                end
                LOAD: begin
                    if (take) begin
                        cnt <= cnt + 8'd1;
                        if (!a_full) begin
                            slot_a <= bus.in_data;
                            a_full <= 1'b1;
                        end else begin
                            slot_b <= bus.in_data;
                        end
                    end
                end
                ADD: begin
                    acc    <= acc + ext_a + ext_b;
                    slot_a <= '0;
                    slot_b <= '0;
                    a_full <= 1'b0;
                end
                DONE: begin
                    acc <= acc;
                end
                default: begin
                    acc <= acc;
                end
            endcase
        end
    end

`ifdef PSUM_SATURATE_EN
    localparam int WW = ((ACC_W > OUT_W) ? ACC_W : OUT_W) + 1;

    localparam logic signed [WW-1:0] SAT_MAX =
        {{(WW-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
    localparam logic signed [WW-1:0] SAT_MIN =
        {{(WW-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};

    logic signed [WW-1:0] acc_x;

    assign acc_x = {{(WW-ACC_W){acc[ACC_W-1]}}, acc};

    // Clamp the accumulator into the signed result range.
    always_comb begin
        out_q = OUT_W'(acc_x);
        sat_q = 1'b0;
        if (acc_x > SAT_MAX) begin
            out_q = OUT_W'(SAT_MAX);
            sat_q = 1'b1;
        end else if (acc_x < SAT_MIN) begin
            out_q = OUT_W'(SAT_MIN);
            sat_q = 1'b1;
        end
    end
`else
    assign out_q = OUT_W'(acc);
    assign sat_q = 1'b0;
`endif

    assign bus.busy      = busy;
    assign bus.in_ready  = in_ready;
    assign bus.out_valid = out_valid;
    assign bus.add_en    = add_en;
    assign bus.out_data  = out_q;
    assign bus.out_sat   = sat_q;

endmodule
